// File: rtl/fb_bank_manager_pkg.sv
// Shared types and defaults for the frame buffer bank manager.
package fbPackage;

    typedef enum logic [1:0] {
        FREE,
        WRITING,
        READY,
        READING
    } bank_state_t;

    localparam int NUM_BANKS_DEF   = 3;
    localparam int FRAME_WORDS_DEF = 10752;

endpackage

// File: rtl/fb_bank_alloc.sv
// Bank ownership tracker: decides which bank the writer fills and which bank scanout reads.
module fb_bank_alloc
    import fbPackage::*;
#(
    parameter int NUM_BANKS = NUM_BANKS_DEF,
    localparam int BANK_W = $clog2(NUM_BANKS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              promote,
    input  logic              swap,
    output logic [BANK_W-1:0] wr_bank,
    output logic [BANK_W-1:0] rd_bank,
    output logic [BANK_W-1:0] rd_bank_nxt,
    output logic              blocked,
    output logic              dropped,
    output logic              repeated
);

    bank_state_t       state_q [NUM_BANKS];
    bank_state_t       state_d [NUM_BANKS];
    logic [BANK_W-1:0] wr_bank_nxt;
    logic              blocked_nxt;
    logic              ready_a, free_a, ready_b;
    logic [BANK_W-1:0] ready_a_idx, free_idx, ready_b_idx;

    always_comb begin
        state_d     = state_q;
        wr_bank_nxt = wr_bank;
        rd_bank_nxt = rd_bank;
        blocked_nxt = blocked;
        dropped     = 1'b0;
        repeated    = 1'b0;
        ready_a     = 1'b0;
        ready_a_idx = '0;
        free_a      = 1'b0;
        free_idx    = '0;
        ready_b     = 1'b0;
        ready_b_idx = '0;

        for (int unsigned i = 0; i < NUM_BANKS; i++) begin
            if (!ready_a && state_q[i] == READY) begin
                ready_a     = 1'b1;
                ready_a_idx = BANK_W'(i);
            end
            if (!free_a && state_q[i] == FREE) begin
                free_a   = 1'b1;
                free_idx = BANK_W'(i);
            end
        end

        if (promote) begin
            state_d[wr_bank] = READY;
            if (ready_a) begin
                state_d[ready_a_idx] = WRITING;
                wr_bank_nxt          = ready_a_idx;
                dropped              = 1'b1;
            end else if (free_a) begin
                state_d[free_idx] = WRITING;
                wr_bank_nxt       = free_idx;
            end else begin
                blocked_nxt = 1'b1;
            end
        end

        // Reader sees the post-promotion view so a frame finishing this cycle is taken at once.
        for (int unsigned i = 0; i < NUM_BANKS; i++) begin
            if (!ready_b && state_d[i] == READY) begin
                ready_b     = 1'b1;
                ready_b_idx = BANK_W'(i);
            end
        end

        if (swap) begin
            if (ready_b) begin
                state_d[rd_bank]     = FREE;
                state_d[ready_b_idx] = READING;
                rd_bank_nxt          = ready_b_idx;
                if (blocked_nxt) begin
                    state_d[rd_bank] = WRITING;
                    wr_bank_nxt      = rd_bank;
                    blocked_nxt      = 1'b0;
                end
            end else begin
                repeated = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_BANKS; i++) begin
                if (i == 0)
                    state_q[i] <= WRITING;
                else if (i == NUM_BANKS - 1)
                    state_q[i] <= READING;
                else
                    state_q[i] <= FREE;
            end
            wr_bank <= '0;
            rd_bank <= BANK_W'(NUM_BANKS - 1);
            blocked <= 1'b0;
        end else begin
            state_q <= state_d;
            wr_bank <= wr_bank_nxt;
            rd_bank <= rd_bank_nxt;
            blocked <= blocked_nxt;
        end
    end

endmodule

// File: rtl/fb_bank_manager.sv
// N-bank capture/scanout frame buffer manager: routes whole frames between the writer and the reader.
module fb_bank_manager
    import fbPackage::*;
#(
    parameter int NUM_BANKS   = NUM_BANKS_DEF,
    parameter int ADDR_W      = 14,
    parameter int DATA_W      = 36,
    parameter int FRAME_WORDS = FRAME_WORDS_DEF,
    parameter int CNT_W       = 16,
    localparam int BANK_W = $clog2(NUM_BANKS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_sof,
    input  logic                     wr_eof,
    input  logic                     wr_we,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     rd_sof,
    input  logic [ADDR_W-1:0]        rd_addr,
    output logic                     mem_we,
    output logic [BANK_W+ADDR_W-1:0] mem_waddr,
    output logic [DATA_W-1:0]        mem_wdata,
    output logic [BANK_W+ADDR_W-1:0] mem_raddr,
    output logic [BANK_W-1:0]        wr_bank,
    output logic [BANK_W-1:0]        rd_bank,
    output logic                     frame_dropped,
    output logic                     frame_repeated,
    output logic                     frame_short,
    output logic                     addr_err,
    output logic [CNT_W-1:0]         frames_done
);

    localparam int WC_W = ADDR_W + 1;

    logic              in_frame, frame_live;
    logic [WC_W-1:0]   wcnt, cnt_base, cnt_eff;
    logic              fr_active, fr_live, addr_ok, wr_ok, full;
    logic              eof_hit, promote, eof_short, eof_drop, sof_short;
    logic              blocked, alloc_dropped, alloc_repeated;
    logic [BANK_W-1:0] rd_bank_nxt;

    fb_bank_alloc #(.NUM_BANKS(NUM_BANKS)) u_alloc (
        .clk         (clk),
        .rst         (rst),
        .promote     (promote),
        .swap        (rd_sof),
        .wr_bank     (wr_bank),
        .rd_bank     (rd_bank),
        .rd_bank_nxt (rd_bank_nxt),
        .blocked     (blocked),
        .dropped     (alloc_dropped),
        .repeated    (alloc_repeated)
    );

    // A frame started while blocked stays unwritable even if the reader frees a bank mid-frame.
    always_comb begin
        fr_active = wr_sof | in_frame;
        fr_live   = wr_sof ? !blocked : frame_live;
        addr_ok   = {1'b0, wr_addr} < WC_W'(FRAME_WORDS);
        wr_ok     = fr_active & fr_live & wr_we & addr_ok;
        cnt_base  = wr_sof ? '0 : wcnt;
        cnt_eff   = cnt_base + WC_W'(wr_ok);
        full      = cnt_eff == WC_W'(FRAME_WORDS);
        eof_hit   = wr_eof & in_frame & !wr_sof;
        promote   = eof_hit & frame_live & full;
        eof_short = eof_hit & frame_live & !full;
        eof_drop  = eof_hit & !frame_live;
        sof_short = wr_sof & in_frame & frame_live;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            in_frame       <= 1'b0;
            frame_live     <= 1'b0;
            wcnt           <= '0;
            mem_we         <= 1'b0;
            mem_waddr      <= '0;
            mem_wdata      <= '0;
            mem_raddr      <= '0;
            frame_dropped  <= 1'b0;
            frame_repeated <= 1'b0;
            frame_short    <= 1'b0;
            addr_err       <= 1'b0;
            frames_done    <= '0;
        end else begin
            mem_we         <= wr_ok;
            mem_waddr      <= {wr_bank, wr_addr};
            mem_wdata      <= wr_data;
            mem_raddr      <= {rd_bank_nxt, rd_addr};
            frame_dropped  <= alloc_dropped | eof_drop;
            frame_repeated <= alloc_repeated;
            frame_short    <= eof_short | sof_short;
            if (fr_active && wr_we && !addr_ok)
                addr_err <= 1'b1;
            if (promote)
                frames_done <= frames_done + CNT_W'(1);
            if (wr_sof) begin
                in_frame   <= 1'b1;
                frame_live <= !blocked;
                wcnt       <= cnt_eff;
            end else if (eof_hit) begin
                in_frame   <= 1'b0;
                frame_live <= 1'b0;
                wcnt       <= '0;
            end else begin
                wcnt       <= cnt_eff;
            end
        end
    end

endmodule
